// File: rtl/regfile_wr_arb.sv
// Round-robin writeback arbiter with registered regfile write port,
// plus pending-write scoreboard for decode-stage RAW hazard stalls.
module regfile_wr_arb #(
  parameter int NREQ = 3,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_num,
  input  logic [DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              wr_en,
  output logic [4:0]        wr_num,
  output logic [DW-1:0]     wr_data,
  input  logic              issue_en,
  input  logic [4:0]        issue_num,
  input  logic              flush,
  input  logic [4:0]        rd0_num,
  input  logic [4:0]        rd1_num,
  output logic              rd0_busy,
  output logic              rd1_busy,
  output logic              stall,
  output logic [31:0]       busy_vec
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] nxt_ptr;
  logic          found;
  logic [4:0]    win_num;
  logic [DW-1:0] win_data;

  always_comb begin
    int j;
    j         = 0;
    found     = 1'b0;
    win       = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
    if (found) req_ready[win] = 1'b1;
  end

  always_comb begin
    nxt_ptr = win + 1'b1;
    if (int'(win) == NREQ - 1) nxt_ptr = '0;
  end

  assign win_num  = req_num[5*win +: 5];
  assign win_data = req_data[DW*win +: DW];

  // r0 writes are granted but never raise wr_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      wr_en   <= 1'b0;
      wr_num  <= '0;
      wr_data <= '0;
    end else if (found) begin
      rr_ptr  <= nxt_ptr;
      wr_en   <= (win_num != 5'd0);
      wr_num  <= win_num;
      wr_data <= win_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  logic [31:0] busy;
  logic [31:0] clr;
  logic [31:0] set;
  logic [31:0] busy_nxt;

  // set is applied after clear so a re-issue wins over a commit
  always_comb begin
    clr = '0;
    set = '0;
    if (wr_en) clr = 32'd1 << wr_num;
    if (issue_en && issue_num != 5'd0) set = 32'd1 << issue_num;
    busy_nxt = (busy & ~clr) | set;
    if (flush) busy_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= {busy_nxt[31:1], 1'b0};
    end
  end

  assign busy_vec = busy;
  assign rd0_busy = (rd0_num != 5'd0) && busy[rd0_num];
  assign rd1_busy = (rd1_num != 5'd0) && busy[rd1_num];
  assign stall    = rd0_busy | rd1_busy;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Randomized + directed bench for regfile_wr_arb with a queue-based
// write scoreboard and a behavioural arbitration/busy model.
module tb_regfile_wr_arb;

  localparam int NREQ = 3;
  localparam int DW   = 32;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_num;
  logic [DW*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wr_en;
  logic [4:0]        wr_num;
  logic [DW-1:0]     wr_data;
  logic              issue_en;
  logic [4:0]        issue_num;
  logic              flush;
  logic [4:0]        rd0_num;
  logic [4:0]        rd1_num;
  logic              rd0_busy;
  logic              rd1_busy;
  logic              stall;
  logic [31:0]       busy_vec;

  regfile_wr_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_num(req_num),
    .req_data(req_data), .req_ready(req_ready),
    .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
    .issue_en(issue_en), .issue_num(issue_num),
    .flush(flush),
    .rd0_num(rd0_num), .rd1_num(rd1_num),
    .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
    .stall(stall), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  num;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  logic [31:0] mbusy;
  int          m_ptr;
  logic        m_out_en;
  logic [4:0]  m_out_num;
  int          last_win;

  logic [NREQ-1:0] pend_v;
  logic [4:0]      pend_n [NREQ];
  logic [31:0]     pend_d [NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Write monitor: each expected write must appear exactly on its cycle
  always @(negedge clk) begin
    wr_t e;
    if (cyc > 0) begin
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_en", 32'(wr_en), 32'd1);
        chk("wr_num", 32'(wr_num), 32'(e.num));
        chk("wr_data", wr_data, e.data);
      end else begin
        chk("wr_idle", 32'(wr_en), 32'd0);
      end
    end
  end

  function automatic int model_win();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v,
                         input logic [4:0] n, input logic [31:0] d);
    req_valid[i]      = v;
    req_num[5*i +: 5] = n;
    req_data[DW*i +: DW] = d;
  endtask

  task automatic tick();
    int          w;
    logic [31:0] nb;
    logic [4:0]  n;
    #1;
    w = model_win();
    chk("ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
    chk("busy_vec", busy_vec, mbusy);
    chk("rd0_busy", 32'(rd0_busy),
        32'((rd0_num != 0) && mbusy[rd0_num]));
    chk("rd1_busy", 32'(rd1_busy),
        32'((rd1_num != 0) && mbusy[rd1_num]));
    chk("stall", 32'(stall),
        32'(((rd0_num != 0) && mbusy[rd0_num]) ||
            ((rd1_num != 0) && mbusy[rd1_num])));
    nb = mbusy;
    if (m_out_en) nb[m_out_num] = 1'b0;
    if (issue_en && issue_num != 0) nb[issue_num] = 1'b1;
    if (flush) nb = '0;
    mbusy = nb;
    if (w >= 0) begin
      n = req_num[5*w +: 5];
      m_out_en  = (n != 0);
      m_out_num = n;
      if (n != 0)
        exp_q.push_back('{cyc + 1, n, req_data[DW*w +: DW]});
      m_ptr = (w + 1) % NREQ;
    end else begin
      m_out_en = 1'b0;
    end
    last_win = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    issue_en  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    pend_v = '0;
    #1 rst_n = 1'b0;
    exp_q.delete();
    mbusy    = '0;
    m_ptr    = 0;
    m_out_en = 1'b0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_num", 32'(wr_num), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int order [12] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 2, 0};

  initial begin
    int g;
    rst_n     = 1'b0;
    req_valid = '0;
    req_num   = '0;
    req_data  = '0;
    issue_en  = 1'b0;
    issue_num = '0;
    flush     = 1'b0;
    rd0_num   = '0;
    rd1_num   = '0;
    pend_v    = '0;
    @(posedge clk);
    #1;
    do_reset();

    // round robin: all valid, then requester 1 drops out
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, (i != 1) || (s < 8), 5'(10 + i), 32'h100 + i);
      #1;
      g = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
      chk("rr_order", g, order[s]);
      tick();
    end
    idle_inputs();
    tick();

    // single write
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("single_ready", 32'(req_ready), 32'b010);
    tick();
    idle_inputs();
    tick();
    tick();

    // scoreboard lifecycle on r7
    rd0_num = 5'd7;
    issue_en = 1'b1;
    issue_num = 5'd7;
    tick();
    issue_en = 1'b0;
    chk("life_stall", 32'(stall), 32'd1);
    tick();
    tick();
    set_req(0, 1'b1, 5'd7, 32'h7777);
    tick();
    idle_inputs();
    tick();
    tick();
    chk("life_clear", 32'(rd0_busy), 32'd0);

    // simultaneous set/clear on r9, then r0 issue and write
    issue_en = 1'b1;
    issue_num = 5'd9;
    tick();
    issue_en = 1'b0;
    set_req(0, 1'b1, 5'd9, 32'h9999);
    tick();
    idle_inputs();
    issue_en = 1'b1;
    issue_num = 5'd9;
    tick();
    issue_en = 1'b0;
    chk("setclr_r9", 32'(busy_vec[9]), 32'd1);
    issue_en = 1'b1;
    issue_num = 5'd0;
    tick();
    issue_en = 1'b0;
    set_req(2, 1'b1, 5'd0, 32'h1234);
    tick();
    idle_inputs();
    chk("r0_drop", 32'(wr_en), 32'd0);
    tick();

    // flush with concurrent issue and in-flight write
    issue_en = 1'b1;
    issue_num = 5'd3;
    tick();
    issue_num = 5'd4;
    tick();
    issue_num = 5'd6;
    flush = 1'b1;
    set_req(0, 1'b1, 5'd3, 32'h3333);
    tick();
    idle_inputs();
    chk("flush_busy", busy_vec, 32'd0);
    chk("flush_wr_en", 32'(wr_en), 32'd1);
    chk("flush_wr_num", 32'(wr_num), 32'd3);
    tick();

    // randomized traffic with a mid-run reset
    for (int c = 0; c < 500; c++) begin
      if (c == 250) do_reset();
      for (int i = 0; i < NREQ; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
          pend_v[i] = 1'b1;
          pend_n[i] = 5'($urandom_range(0, 31));
          pend_d[i] = $urandom;
        end
        set_req(i, pend_v[i], pend_n[i], pend_d[i]);
      end
      issue_en  = 1'($urandom_range(0, 1));
      issue_num = 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 39) == 0);
      rd0_num   = 5'($urandom_range(0, 31));
      rd1_num   = 5'($urandom_range(0, 31));
      tick();
      if (last_win >= 0) pend_v[last_win] = 1'b0;
    end

    idle_inputs();
    repeat (3) tick();
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arb.md
# regfile_wr_arb

Write-port arbiter and pending-write scoreboard for the 32x32 register file (r0 hardwired zero, one synchronous write port, two combinational read ports). It merges up to NREQ writeback requesters (ALU, load unit, mul/div) onto the single write port with round-robin fairness and a registered output stage. It also tracks destination registers with writes in flight, so the decode stage can stall on read-after-write hazards.

## Interface
- NREQ, 3, number of writeback requesters (2..4)
- DW, 32, data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester write request
- req_num  in  5*NREQ  destination register, requester i at [5i+:5]
- req_data  in  DW*NREQ  write data, requester i at [DW*i+:DW]
- req_ready  out  NREQ  grant; a transfer occurs when valid & ready
- wr_en  out  1  to regfile write enable (registered)
- wr_num  out  5  to regfile write register number (registered)
- wr_data  out  DW  to regfile write data (registered)
- issue_en  in  1  decode issues an instruction that writes issue_num
- issue_num  in  5  destination of the issued instruction
- flush  in  1  synchronous clear of the scoreboard
- rd0_num, rd1_num  in  5 each  decode-stage source register numbers
- rd0_busy, rd1_busy  out  1 each  source has a pending write (combinational)
- stall  out  1  rd0_busy | rd1_busy
- busy_vec  out  32  scoreboard state; bit 0 always 0

## Operation
- Arbitration:
  - The round-robin pointer rr_ptr (0..NREQ-1) selects the first requester with req_valid high at index rr_ptr, rr_ptr+1, … mod NREQ. That requester is the winner.
  - req_ready is one-hot or zero. Only the winner sees ready. It is combinational from req_valid and rr_ptr.
  - The output stage drains every cycle, so ready never depends on downstream state.
  - Requesters hold valid, num and data stable until ready.
  - On a grant to requester i, rr_ptr <= (i+1) mod NREQ. With no valid requester, rr_ptr holds.
- Output stage:
  - On a grant, the next edge loads wr_en = (num != 0), wr_num = num, wr_data = data.
  - With no grant, wr_en <= 0, and wr_num/wr_data hold their values.
  - A write to r0 is accepted (ready asserted) and dropped.
- Scoreboard:
  - busy[n] is set on the edge where issue_en=1 and issue_num=n, for n != 0.
  - busy[n] is cleared on the edge where wr_en=1 and wr_num=n. This is the same edge on which the register file commits the write.
  - Set and clear of the same register on the same edge: set wins (a newer write is pending).
  - Set and clear of different registers on the same edge: both take effect.
  - flush=1: busy_vec <= 0 on that edge and overrides the same-cycle issue_en. It does not affect arbitration or the output stage; in-flight writes still commit.
- Hazard outputs:
  - rdX_busy = busy[rdX_num], and 0 when rdX_num = 0.
  - There is no bypass. A register becomes readable the cycle after busy clears, because the regfile reads combinationally and the write was committed on the clearing edge.

## Timing
- Reset (async assert, sync release): wr_en=0, wr_num=0, wr_data=0, busy_vec=0, rr_ptr=0. Combinational outputs follow from these.
- Reset mid-operation drops any accepted but uncommitted write, and all pending busy bits are lost.
- Latency:
  - Request accept to wr_en high: 1 cycle.
  - Accept to busy clear: 2 edges (load output register, then commit).
- Throughput: one write per cycle sustained. Each requester is served at least once every NREQ grant cycles.
- Register numbers are 5 bits with no wrap cases. rr_ptr wraps NREQ-1 -> 0.

## Test plan
- Reset then idle:
  - Stimulus: rst_n low mid-cycle.
  - Required: outputs zero immediately, busy_vec=0, req_ready=0 with no valid.
- Single write:
  - Stimulus: requester 1 valid, num=5, data=0xDEADBEEF.
  - Required: ready[1] same cycle; the next cycle wr_en=1, wr_num=5, wr_data=0xDEADBEEF; the following cycle wr_en=0.
- Round-robin, NREQ=3:
  - Stimulus: all three requesters valid continuously.
  - Required: grant order 0,1,2,0,1,2. Dropping requester 1 after its first grant gives 0,1,2,0,2,0.
- Scoreboard lifecycle:
  - Stimulus: issue r7, then rd0_num=7; a requester writes r7 three cycles later.
  - Required: rd0_busy=1 and stall=1 from the cycle after issue until the commit edge; 0 afterwards.
- Simultaneous set/clear:
  - Stimulus: issue r9 on the same edge a committed write to r9 clears it.
  - Required: busy_vec[9]=1 afterwards.
  - Stimulus: issue r0.
  - Required: busy_vec unchanged, and a write to r0 gives wr_en=0.
- Flush:
  - Stimulus: busy r3 and r4 set, then flush concurrent with issue r6.
  - Required: busy_vec=0 next cycle. An in-flight write to r3 still produces wr_en=1, wr_num=3.
